// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer driving SR push/pop, EPC/CAUSE and fetch redirect
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          NIRQ       = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ie,
  input  logic            s_u,
  input  logic            instr_valid,
  input  logic [31:0]     pc,
  input  logic            bd,
  input  logic            syscall,
  input  logic            ri,
  input  logic            ovf,
  input  logic            rfe_instr,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] im,
  output logic            exception,
  output logic            rfe,
  output logic            flush,
  output logic            pc_load,
  output logic [31:0]     pc_target,
  output logic            busy,
  output logic [31:0]     epc,
  output logic [31:0]     cause
);

  typedef enum logic [1:0] {IDLE, EXC, RFE_S, COOL} state_t;

  state_t      state_q, state_d;
  logic        exception_q, exception_d;
  logic        rfe_q, rfe_d;
  logic        redirect_q, redirect_d;
  logic        busy_q, busy_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;

  logic [7:0]  pend8;
  logic        take_exc, take_rfe;
  logic [4:0]  exc_code;

  always_comb begin
    pend8 = '0;
    pend8[NIRQ-1:0] = irq & im;
  end

  // Synchronous faults need a valid instruction; interrupts are lowest priority and ignore it.
  always_comb begin
    take_exc = 1'b0;
    take_rfe = 1'b0;
    exc_code = 5'd0;
    if (instr_valid && rfe_instr && !s_u) begin
      take_exc = 1'b1;
      exc_code = 5'd11;
    end else if (instr_valid && ri) begin
      take_exc = 1'b1;
      exc_code = 5'd10;
    end else if (instr_valid && ovf) begin
      take_exc = 1'b1;
      exc_code = 5'd12;
    end else if (instr_valid && syscall) begin
      take_exc = 1'b1;
      exc_code = 5'd8;
    end else if (instr_valid && rfe_instr) begin
      take_rfe = 1'b1;
    end else if (ie && |pend8) begin
      take_exc = 1'b1;
      exc_code = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      exception_q <= 1'b0;
      rfe_q       <= 1'b0;
      redirect_q  <= 1'b0;
      busy_q      <= 1'b0;
      pc_target_q <= EXC_VECTOR;
      epc_q       <= '0;
      bd_q        <= 1'b0;
      ip_q        <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      exception_q <= exception_d;
      rfe_q       <= rfe_d;
      redirect_q  <= redirect_d;
      busy_q      <= busy_d;
      pc_target_q <= pc_target_d;
      epc_q       <= epc_d;
      bd_q        <= bd_d;
      ip_q        <= ip_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_exc)      state_d = EXC;
        else if (take_rfe) state_d = RFE_S;
      end
      EXC:     state_d = COOL;
      RFE_S:   state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pulse leaves a flop.
  always_comb begin
    exception_d = (state_d == EXC);
    rfe_d       = (state_d == RFE_S);
    redirect_d  = (state_d == EXC) || (state_d == RFE_S);
    busy_d      = (state_d != IDLE);
    pc_target_d = pc_target_q;
    if (state_d == EXC)   pc_target_d = EXC_VECTOR;
    if (state_d == RFE_S) pc_target_d = epc_q;
    epc_d  = epc_q;
    bd_d   = bd_q;
    code_d = code_q;
    ip_d   = ip_q;
    if (state_q == IDLE) begin
      ip_d = pend8;
      if (take_exc) begin
        epc_d  = pc;
        bd_d   = bd;
        code_d = exc_code;
      end
    end
  end

  assign exception = exception_q;
  assign rfe       = rfe_q;
  assign flush     = redirect_q;
  assign pc_load   = redirect_q;
  assign busy      = busy_q;
  assign pc_target = pc_target_q;
  assign epc       = epc_q;
  assign cause     = {bd_q, 15'b0, ip_q, 1'b0, code_q, 2'b00};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed scoreboard bench for exc_ctrl
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst, ie, s_u, instr_valid, bd, syscall, ri, ovf, rfe_instr;
  logic [31:0] pc;
  logic [5:0]  irq, im;
  logic        exception, rfe, flush, pc_load, busy;
  logic [31:0] pc_target, epc, cause;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        exc;
    logic        rf;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] cause;
  } exp_t;
  exp_t sb[$];

  exc_ctrl #(.EXC_VECTOR(VEC), .NIRQ(6)) dut (
    .clk(clk), .rst(rst), .ie(ie), .s_u(s_u), .instr_valid(instr_valid),
    .pc(pc), .bd(bd), .syscall(syscall), .ri(ri), .ovf(ovf),
    .rfe_instr(rfe_instr), .irq(irq), .im(im),
    .exception(exception), .rfe(rfe), .flush(flush), .pc_load(pc_load),
    .pc_target(pc_target), .busy(busy), .epc(epc), .cause(cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_cause(input logic b, input logic [7:0] ip, input logic [4:0] code);
    return {b, 15'b0, ip, 1'b0, code, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    ie = 0; s_u = 1; instr_valid = 0; bd = 0; syscall = 0; ri = 0;
    ovf = 0; rfe_instr = 0; irq = '0; im = '0; pc = '0;
  endtask

  task automatic push(input logic e, input logic r, input logic [31:0] t,
                      input logic [31:0] ep, input logic [31:0] c);
    exp_t x;
    x.exc = e; x.rf = r; x.tgt = t; x.epc = ep; x.cause = c;
    sb.push_back(x);
  endtask

  // Waits (bounded) for a pulse, then pops and compares the scoreboard head.
  task automatic wait_event(input string tag);
    exp_t x;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exception || rfe) && n < 6);
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_exception"}, exception, x.exc);
      chk({tag, "_rfe"}, rfe, x.rf);
      chk({tag, "_pc_target"}, pc_target, x.tgt);
      chk({tag, "_epc"}, epc, x.epc);
      chk({tag, "_cause"}, cause, x.cause);
    end
    chk({tag, "_flush"}, flush, 1);
    chk({tag, "_pc_load"}, pc_load, 1);
    chk({tag, "_busy"}, busy, 1);
    clear_stim();
  endtask

  task automatic cool_idle(input string tag);
    @(negedge clk);
    chk({tag, "_cool_pulses"}, {exception, rfe, flush, pc_load}, 0);
    chk({tag, "_cool_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_exception"}, exception, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stim();
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset_pulses", {exception, rfe, flush, pc_load, busy}, 0);
    chk("reset_epc", epc, 0);
    chk("reset_cause", cause, 0);
    chk("reset_pc_target", pc_target, VEC);
    rst = 1;
    @(negedge clk);

    // syscall from supervisor mode
    pc = 32'h40; instr_valid = 1; s_u = 1; syscall = 1;
    push(1, 0, VEC, 32'h40, mk_cause(0, 8'h00, 5'd8));
    wait_event("syscall");
    cool_idle("syscall");

    // rfe in user mode is a privilege fault
    pc = 32'h100; instr_valid = 1; s_u = 0; rfe_instr = 1;
    push(1, 0, VEC, 32'h100, mk_cause(0, 8'h00, 5'd11));
    wait_event("user_rfe");
    cool_idle("user_rfe");

    // set up epc=0x200, then a legal rfe
    pc = 32'h200; instr_valid = 1; syscall = 1;
    push(1, 0, VEC, 32'h200, mk_cause(0, 8'h00, 5'd8));
    wait_event("pre_rfe");
    cool_idle("pre_rfe");
    pc = 32'h204; instr_valid = 1; s_u = 1; rfe_instr = 1;
    push(0, 1, 32'h200, 32'h200, mk_cause(0, 8'h00, 5'd8));
    wait_event("legal_rfe");
    cool_idle("legal_rfe");

    // interrupt held pending while ie=0
    pc = 32'h300; irq = 6'b000100; im = 6'b000100; ie = 0;
    repeat (3) begin
      @(negedge clk);
      chk("irq_gated_exception", {exception, busy}, 0);
    end
    chk("irq_live_ip", cause[15:8], 8'h04);
    ie = 1;
    push(1, 0, VEC, 32'h300, mk_cause(0, 8'h04, 5'd0));
    wait_event("irq");
    cool_idle("irq");

    // ovf beats syscall and interrupt; requests during busy are ignored
    pc = 32'h400; instr_valid = 1; bd = 1; ovf = 1; syscall = 1;
    irq = 6'b000001; im = 6'b000011; ie = 1;
    push(1, 0, VEC, 32'h400, mk_cause(1, 8'h01, 5'd12));
    wait_event("ovf_prio");
    pc = 32'h600; instr_valid = 1; syscall = 1;
    @(negedge clk);
    chk("busy_ignore_cool", {exception, busy}, 32'h1);
    @(negedge clk);
    chk("busy_ignore_idle", {exception, busy}, 0);
    chk("busy_ignore_epc", epc, 32'h400);
    clear_stim();
    @(negedge clk);
    chk("busy_ignore_after", {exception, busy}, 0);

    // ri beats ovf and syscall
    pc = 32'h700; instr_valid = 1; ri = 1; ovf = 1; syscall = 1;
    push(1, 0, VEC, 32'h700, mk_cause(0, 8'h00, 5'd10));
    wait_event("ri_prio");
    cool_idle("ri_prio");

    // reset while in EXC
    pc = 32'h500; instr_valid = 1; syscall = 1;
    push(1, 0, VEC, 32'h500, mk_cause(0, 8'h00, 5'd8));
    wait_event("pre_reset");
    rst = 0;
    #1;
    chk("midreset_pulses", {exception, rfe, flush, pc_load, busy}, 0);
    chk("midreset_epc", epc, 0);
    chk("midreset_cause", cause, 0);
    chk("midreset_pc_target", pc_target, VEC);
    @(negedge clk);
    chk("midreset_held", {exception, busy}, 0);
    rst = 1;
    @(negedge clk);
    pc = 32'h44; instr_valid = 1; syscall = 1;
    push(1, 0, VEC, 32'h44, mk_cause(0, 8'h00, 5'd8));
    wait_event("post_reset");
    cool_idle("post_reset");

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
